// File: rtl/wt_l15_req_arbiter.sv
// Round-robin arbiter that shares the L1.5 request channel between the I-cache and D-cache miss
// units, registers the winning header and caps outstanding transactions per requester.
module wt_l15_req_arbiter #(
    parameter int unsigned ADDR_W    = 40,
    parameter int unsigned TID_W     = 2,
    parameter int unsigned MAX_OUT_I = 1,
    parameter int unsigned MAX_OUT_D = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // I-cache request
    input  logic              ic_req_i,
    output logic              ic_ready_o,
    input  logic              ic_nc_i,
    input  logic [TID_W-1:0]  ic_tid_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    // D-cache request
    input  logic              dc_req_i,
    output logic              dc_ready_o,
    input  logic [4:0]        dc_rqtype_i,
    input  logic              dc_nc_i,
    input  logic [2:0]        dc_size_i,
    input  logic [TID_W-1:0]  dc_tid_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [63:0]       dc_data_i,
    input  logic [3:0]        dc_amo_op_i,
    // L1.5 header
    output logic              l15_val_o,
    output logic [4:0]        l15_rqtype_o,
    output logic              l15_nc_o,
    output logic [2:0]        l15_size_o,
    output logic [TID_W-1:0]  l15_tid_o,
    output logic [ADDR_W-1:0] l15_addr_o,
    output logic [63:0]       l15_data_o,
    output logic [3:0]        l15_amo_op_o,
    input  logic              l15_header_ack_i,
    // L1.5 return
    input  logic              rtrn_val_i,
    input  logic              rtrn_ack_i,
    input  logic [3:0]        rtrn_type_i,
    output logic              ic_busy_o,
    output logic              dc_busy_o
);

    localparam int unsigned CNT_I_W = $clog2(MAX_OUT_I + 1);
    localparam int unsigned CNT_D_W = $clog2(MAX_OUT_D + 1);

    localparam logic [4:0] RQ_IMISS  = 5'b10000;
    localparam logic [4:0] RQ_ATOMIC = 5'b00110;

    localparam logic [3:0] RT_LOAD   = 4'b0000;
    localparam logic [3:0] RT_IFILL  = 4'b0001;
    localparam logic [3:0] RT_ST_ACK = 4'b0100;
    localparam logic [3:0] RT_INT    = 4'b0111;
    localparam logic [3:0] RT_ATOMIC = 4'b1110;

    typedef enum logic [1:0] {StIdle, StSendI, StSendD} state_e;

    state_e               r_state, w_state_next;
    logic                 r_last_i;
    logic [CNT_I_W-1:0]   r_cnt_i, w_cnt_i_next;
    logic [CNT_D_W-1:0]   r_cnt_d, w_cnt_d_next;

    logic [4:0]           r_rqtype;
    logic                 r_nc;
    logic [2:0]           r_size;
    logic [TID_W-1:0]     r_tid;
    logic [ADDR_W-1:0]    r_addr;
    logic [63:0]          r_data;
    logic [3:0]           r_amo_op;

    logic w_elig_i, w_elig_d, w_can_grant, w_grant_i, w_grant_d;
    logic w_rtrn, w_dec_i, w_dec_d;

    assign w_elig_i    = ic_req_i && (r_cnt_i < CNT_I_W'(MAX_OUT_I));
    assign w_elig_d    = dc_req_i && (r_cnt_d < CNT_D_W'(MAX_OUT_D));
    assign w_can_grant = (r_state == StIdle) || l15_header_ack_i;
    // On a tie the requester that did not win last time goes first.
    assign w_grant_i   = w_can_grant && w_elig_i && (!w_elig_d || !r_last_i);
    assign w_grant_d   = w_can_grant && w_elig_d && (!w_elig_i || r_last_i);

    assign w_rtrn  = rtrn_val_i && rtrn_ack_i;
    assign w_dec_i = w_rtrn && (rtrn_type_i == RT_IFILL) && (r_cnt_i != '0);
    assign w_dec_d = w_rtrn && (r_cnt_d != '0) &&
                     ((rtrn_type_i == RT_LOAD) || (rtrn_type_i == RT_ST_ACK) ||
                      (rtrn_type_i == RT_INT)  || (rtrn_type_i == RT_ATOMIC));

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state
    always_comb begin
        w_state_next = r_state;
        if (w_grant_i) begin
            w_state_next = StSendI;
        end else if (w_grant_d) begin
            w_state_next = StSendD;
        end else if ((r_state != StIdle) && l15_header_ack_i) begin
            w_state_next = StIdle;
        end
    end

    // FSM outputs
    always_comb begin
        l15_val_o  = (r_state != StIdle);
        ic_ready_o = w_grant_i;
        dc_ready_o = w_grant_d;
    end

    always_comb begin
        w_cnt_i_next = r_cnt_i;
        if (w_grant_i && !w_dec_i) begin
            w_cnt_i_next = r_cnt_i + CNT_I_W'(1);
        end else if (!w_grant_i && w_dec_i) begin
            w_cnt_i_next = r_cnt_i - CNT_I_W'(1);
        end
    end

    always_comb begin
        w_cnt_d_next = r_cnt_d;
        if (w_grant_d && !w_dec_d) begin
            w_cnt_d_next = r_cnt_d + CNT_D_W'(1);
        end else if (!w_grant_d && w_dec_d) begin
            w_cnt_d_next = r_cnt_d - CNT_D_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_i <= 1'b0;
            r_cnt_i  <= '0;
            r_cnt_d  <= '0;
        end else begin
            r_cnt_i <= w_cnt_i_next;
            r_cnt_d <= w_cnt_d_next;
            if (w_grant_i) begin
                r_last_i <= 1'b1;
            end else if (w_grant_d) begin
                r_last_i <= 1'b0;
            end
        end
    end

    // Header register only loads on a grant, so it holds while waiting for the ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rqtype <= '0;
            r_nc     <= 1'b0;
            r_size   <= '0;
            r_tid    <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_amo_op <= '0;
        end else if (w_grant_i) begin
            r_rqtype <= RQ_IMISS;
            r_nc     <= ic_nc_i;
            r_size   <= 3'b111;
            r_tid    <= ic_tid_i;
            r_addr   <= ic_addr_i;
            r_data   <= '0;
            r_amo_op <= '0;
        end else if (w_grant_d) begin
            r_rqtype <= dc_rqtype_i;
            r_nc     <= dc_nc_i;
            r_size   <= dc_size_i;
            r_tid    <= dc_tid_i;
            r_addr   <= dc_addr_i;
            r_data   <= dc_data_i;
            r_amo_op <= (dc_rqtype_i == RQ_ATOMIC) ? dc_amo_op_i : 4'b0000;
        end
    end

    assign l15_rqtype_o = r_rqtype;
    assign l15_nc_o     = r_nc;
    assign l15_size_o   = r_size;
    assign l15_tid_o    = r_tid;
    assign l15_addr_o   = r_addr;
    assign l15_data_o   = r_data;
    assign l15_amo_op_o = r_amo_op;

    assign ic_busy_o = (r_cnt_i != '0);
    assign dc_busy_o = (r_cnt_d != '0);

endmodule
